// File: rtl/unary_add_seq.sv
// unary_add_seq: sequencer around the serial unary adder stage.
// Accepts two binary operands over valid/ready, serialises them as front-aligned
// unary streams on A/B (read phase), drains the adder (write phase) by counting
// dout pulses back to binary, captures the carry pulse C, and presents
// {carry, sum} on an output valid/ready handshake. One operation in flight.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op_a, op_b            binary operands          in_valid / in_ready
//   A, B, en, read_or_write  adder control/stream outputs
//   dout, C               registered adder result stream and carry pulse
//   sum, carry            binary result            out_valid / out_ready
//   err                   only with UNARY_SEQ_TIMEOUT_ERR_EN defined: write phase
//                         ended on the MAX_WRITE limit rather than dout==0
//
// Optional feature macro: UNARY_SEQ_TIMEOUT_ERR_EN
module unary_add_seq #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned MAX_WRITE = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    input  logic             dout,
    input  logic             C,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid,
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
    output logic             err,
`endif
    input  logic             out_ready
);

    localparam int unsigned WCW = $clog2(MAX_WRITE + 1);

    typedef enum logic [2:0] {IDLE, READ, FLUSH, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, len_q, len_d;
    logic [WIDTH-1:0] rcnt_q, rcnt_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             a_bit_d, b_bit_d, en_d, rw_d, carry_d, out_valid_d, in_ready_d;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] max_op_c;
    logic             first_write_c, done_by_zero_c, done_by_limit_c;
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
    logic             err_d;
`endif

    assign max_op_c        = (op_a > op_b) ? op_a : op_b;
    // Write cycle 1 still shows read-phase dout, so it is never sampled.
    assign first_write_c   = (wcnt_q == WCW'(1));
    assign done_by_zero_c  = !first_write_c && !dout;
    assign done_by_limit_c = !done_by_zero_c && (wcnt_q == WCW'(MAX_WRITE));

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            opa_q         <= '0;
            opb_q         <= '0;
            len_q         <= '0;
            rcnt_q        <= '0;
            wcnt_q        <= '0;
            A             <= 1'b0;
            B             <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            sum           <= '0;
            carry         <= 1'b0;
            out_valid     <= 1'b0;
            in_ready      <= 1'b1;
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
            err           <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            len_q         <= len_d;
            rcnt_q        <= rcnt_d;
            wcnt_q        <= wcnt_d;
            A             <= a_bit_d;
            B             <= b_bit_d;
            en            <= en_d;
            read_or_write <= rw_d;
            sum           <= sum_d;
            carry         <= carry_d;
            out_valid     <= out_valid_d;
            in_ready      <= in_ready_d;
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
            err           <= err_d;
`endif
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        len_d       = len_q;
        rcnt_d      = rcnt_q;
        wcnt_d      = wcnt_q;
        a_bit_d     = 1'b0;
        b_bit_d     = 1'b0;
        en_d        = 1'b0;
        rw_d        = 1'b0;
        sum_d       = sum;
        carry_d     = carry;
        out_valid_d = out_valid;
        in_ready_d  = 1'b0;
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
        err_d       = err;
`endif

        // Sticky carry over the window where the adder may emit C
        if ((state_q == READ) || (state_q == FLUSH) ||
            ((state_q == WRITE) && first_write_c)) begin
            carry_d = carry | C;
        end

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    in_ready_d = 1'b0;
                    opa_d      = op_a;
                    opb_d      = op_b;
                    len_d      = max_op_c;
                    sum_d      = '0;
                    carry_d    = 1'b0;
                    en_d       = 1'b1;
                    if (max_op_c == '0) begin
                        rcnt_d  = '0;
                        state_d = FLUSH;
                    end else begin
                        // Outputs for read cycle 0 are registered here; rcnt
                        // holds the index of the next read cycle.
                        a_bit_d = (op_a != '0);
                        b_bit_d = (op_b != '0);
                        rcnt_d  = WIDTH'(1);
                        state_d = READ;
                    end
                end
            end
            READ: begin
                en_d = 1'b1;
                if (rcnt_q == len_q) begin
                    state_d = FLUSH;
                end else begin
                    a_bit_d = (rcnt_q < opa_q);
                    b_bit_d = (rcnt_q < opb_q);
                    rcnt_d  = WIDTH'(rcnt_q + WIDTH'(1));
                end
            end
            FLUSH: begin
                en_d    = 1'b1;
                rw_d    = 1'b1;
                wcnt_d  = WCW'(1);
                state_d = WRITE;
            end
            WRITE: begin
                en_d = 1'b1;
                rw_d = 1'b1;
                if (!first_write_c && dout) begin
                    sum_d = WIDTH'(sum + WIDTH'(1));
                end
                if (done_by_zero_c || done_by_limit_c) begin
                    en_d        = 1'b0;
                    rw_d        = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
                    err_d       = done_by_limit_c;
`endif
                end else begin
                    wcnt_d = WCW'(wcnt_q + WCW'(1));
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
                    err_d       = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_unary_add_seq.sv
// Self-checking bench for unary_add_seq with a behavioural serial unary adder.
// Adder model: read phase accumulates A+B, emits a registered C pulse when the
// running total first reaches 7; write phase emits (total mod 8) registered dout
// pulses. A "stuck" mode holds dout at 1 to exercise the write-phase limit.
module tb_unary_add_seq;

    localparam int unsigned W  = 3;
    localparam int unsigned MW = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         A, B, en, read_or_write;
    logic         dout, C;
    logic [W-1:0] sum;
    logic         carry;
    logic         out_valid;
    logic         out_ready = 1'b0;
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
    logic         err;
`endif

    unary_add_seq #(.WIDTH(W), .MAX_WRITE(MW)) dut (
        .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .en(en), .read_or_write(read_or_write),
        .dout(dout), .C(C), .sum(sum), .carry(carry), .out_valid(out_valid),
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
        .err(err),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Adder model
    int   tot = 0;
    logic c_m = 1'b0, dout_m = 1'b0, stuck = 1'b0;
    assign dout = dout_m;
    assign C    = c_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot <= 0; c_m <= 1'b0; dout_m <= 1'b0;
        end else if (en && !read_or_write) begin
            c_m    <= (tot < 7) && (tot + int'(A) + int'(B) >= 7);
            tot    <= tot + int'(A) + int'(B);
            dout_m <= 1'b0;
        end else if (en && read_or_write) begin
            c_m <= 1'b0;
            if (stuck) dout_m <= 1'b1;
            else if (tot % 8 != 0) begin dout_m <= 1'b1; tot <= tot - 1; end
            else dout_m <= 1'b0;
        end else begin
            c_m <= 1'b0; dout_m <= 1'b0; tot <= 0;
        end
    end

    // Free-running pulse monitors; tests take differences
    int a_tot = 0, b_tot = 0, rd_tot = 0;
    always @(negedge clk) begin
        if (en && !read_or_write) begin
            rd_tot <= rd_tot + 1;
            if (A) a_tot <= a_tot + 1;
            if (B) b_tot <= b_tot + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one operand pair (called at a negedge), return when out_valid seen
    task automatic run_op(input int a, input int b, output int lat,
                          output int ap, output int bp, output int rd);
        int  a0, b0, r0;
        bit  acc;
        a0 = a_tot; b0 = b_tot; r0 = rd_tot;
        op_a = W'(a); op_b = W'(b); in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (in_ready) acc = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) chk("out_valid_timeout", lat, 0);
        ap = a_tot - a0; bp = b_tot - b0; rd = rd_tot - r0;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        int a; int b; int s; int c; int lat;
    } vec_t;

    vec_t v[8];
    int   lat, ap, bp, rd;

    initial begin
        v[0] = '{2, 3, 5, 0, 11};
        v[1] = '{4, 3, 7, 1, 14};
        v[2] = '{6, 6, 4, 1, 13};
        v[3] = '{0, 0, 0, 0, 3};
        v[4] = '{1, 1, 2, 0, 6};
        v[5] = '{7, 0, 7, 1, 17};
        v[6] = '{5, 1, 6, 0, 14};
        v[7] = '{7, 7, 6, 1, 16};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_en", int'(en), 0);
        chk("rst_ab", int'({A, B, read_or_write}), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_carry", int'(carry), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, lat, ap, bp, rd);
            chk($sformatf("sum[%0d]", i), int'(sum), v[i].s);
            chk($sformatf("carry[%0d]", i), int'(carry), v[i].c);
            chk($sformatf("latency[%0d]", i), lat, v[i].lat);
            chk($sformatf("a_pulses[%0d]", i), ap, v[i].a);
            chk($sformatf("b_pulses[%0d]", i), bp, v[i].b);
            chk($sformatf("read_flush_cycles[%0d]", i), rd,
                ((v[i].a > v[i].b) ? v[i].a : v[i].b) + 1);
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
            chk($sformatf("err[%0d]", i), int'(err), 0);
`endif
            finish_op();
            chk($sformatf("post_hs_valid[%0d]", i), int'(out_valid), 0);
            chk($sformatf("post_hs_ready[%0d]", i), int'(in_ready), 1);
        end

        // Backpressure in DONE with new operands waiting
        run_op(3, 2, lat, ap, bp, rd);
        op_a = W'(1); op_b = W'(1); in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_sum", int'(sum), 5);
            chk("hold_carry", int'(carry), 0);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_out_valid", int'(out_valid), 1);
        end
        finish_op();
        chk("hold_hs_valid", int'(out_valid), 0);
        chk("hold_hs_ready", int'(in_ready), 1);
        run_op(1, 1, lat, ap, bp, rd);
        chk("queued_sum", int'(sum), 2);
        chk("queued_lat", lat, 6);
        finish_op();

        // Reset in the middle of the read phase
        op_a = W'(7); op_b = W'(7); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midread_en", int'(en), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_en", int'(en), 0);
        chk("midrst_ab_rw", int'({A, B, read_or_write}), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_sum_carry", int'({carry, sum}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1, 1, lat, ap, bp, rd);
        chk("after_rst_sum", int'(sum), 2);
        chk("after_rst_carry", int'(carry), 0);
        finish_op();

        // Adder stuck at dout=1: write phase ends on the limit
        stuck = 1'b1;
        run_op(2, 1, lat, ap, bp, rd);
        chk("timeout_lat", lat, 2 + 1 + MW);
        chk("timeout_valid", int'(out_valid), 1);
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
        chk("timeout_err", int'(err), 1);
`endif
        finish_op();
        stuck = 1'b0;
`ifdef UNARY_SEQ_TIMEOUT_ERR_EN
        chk("timeout_err_clr", int'(err), 0);
`endif
        chk("timeout_hs_ready", int'(in_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
